// File: rtl/sram_arbiter.sv
// Arbitrates the fetch and data ports onto BaseRAM/ExtRAM and runs multi-cycle async-SRAM cycles.
// Optional `define ARB_RR_EN: alternate the grant on simultaneous requests (default: data first).
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter logic [9:0]  BASE_ADDR_HI = 10'h200,
  parameter logic [9:0]  EXT_ADDR_HI  = 10'h201
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,

  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,

  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,

  output logic        busy
);

  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        gnt_data_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        sel_base_q;
  logic        sel_ext_q;
  logic        base_drive_q;
  logic        ext_drive_q;

  logic        pick_data;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be_n;
  logic        hit_base;
  logic        hit_ext;
  logic [31:0] sample;

`ifdef ARB_RR_EN
  logic        last_data_q;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[1:0], data_addr[1:0]};

  assign base_ram_data = base_drive_q ? wdata_q : {32{1'bz}};
  assign ext_ram_data  = ext_drive_q  ? wdata_q : {32{1'bz}};
  assign busy          = (state_q != StIdle);

  always_comb begin
    pick_data = 1'b0;
`ifdef ARB_RR_EN
    // On a conflict, serve whichever port lost last time.
    pick_data = data_req && (!inst_req || !last_data_q);
`else
    pick_data = data_req;
`endif
    req_addr = pick_data ? data_addr : inst_addr;
    req_we   = pick_data && data_we;
    req_be_n = req_we ? ~data_be : 4'h0;
    hit_base = (req_addr[31:22] == BASE_ADDR_HI);
    hit_ext  = (req_addr[31:22] == EXT_ADDR_HI);
    sample   = 32'h0;
    if (sel_base_q)     sample = base_ram_data;
    else if (sel_ext_q) sample = ext_ram_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      gnt_data_q    <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= 32'h0;
      sel_base_q    <= 1'b0;
      sel_ext_q     <= 1'b0;
      base_drive_q  <= 1'b0;
      ext_drive_q   <= 1'b0;
      base_ram_addr <= 20'h0;
      base_ram_be_n <= 4'hF;
      base_ram_ce_n <= 1'b1;
      base_ram_oe_n <= 1'b1;
      base_ram_we_n <= 1'b1;
      ext_ram_addr  <= 20'h0;
      ext_ram_be_n  <= 4'hF;
      ext_ram_ce_n  <= 1'b1;
      ext_ram_oe_n  <= 1'b1;
      ext_ram_we_n  <= 1'b1;
      inst_ack      <= 1'b0;
      data_ack      <= 1'b0;
      inst_rdata    <= 32'h0;
      data_rdata    <= 32'h0;
`ifdef ARB_RR_EN
      last_data_q   <= 1'b1;
`endif
    end else begin
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (inst_req || data_req) begin
            state_q    <= StAccess;
            gnt_data_q <= pick_data;
            we_q       <= req_we;
            wdata_q    <= data_wdata;
            sel_base_q <= hit_base;
            sel_ext_q  <= hit_ext;
            // Unmapped requests spend one dead ACCESS cycle with no chip enabled.
            cnt_q      <= (hit_base || hit_ext) ? 4'd0 : WaitLast;
`ifdef ARB_RR_EN
            last_data_q <= pick_data;
`endif
            if (hit_base) begin
              base_ram_addr <= req_addr[21:2];
              base_ram_ce_n <= 1'b0;
              base_ram_oe_n <= req_we;
              base_ram_we_n <= ~req_we;
              base_ram_be_n <= req_be_n;
              base_drive_q  <= req_we;
            end
            if (hit_ext) begin
              ext_ram_addr <= req_addr[21:2];
              ext_ram_ce_n <= 1'b0;
              ext_ram_oe_n <= req_we;
              ext_ram_we_n <= ~req_we;
              ext_ram_be_n <= req_be_n;
              ext_drive_q  <= req_we;
            end
          end
        end
        StAccess: begin
          if (cnt_q == WaitLast) begin
            state_q       <= StDone;
            base_drive_q  <= 1'b0;
            ext_drive_q   <= 1'b0;
            base_ram_be_n <= 4'hF;
            base_ram_ce_n <= 1'b1;
            base_ram_oe_n <= 1'b1;
            base_ram_we_n <= 1'b1;
            ext_ram_be_n  <= 4'hF;
            ext_ram_ce_n  <= 1'b1;
            ext_ram_oe_n  <= 1'b1;
            ext_ram_we_n  <= 1'b1;
            if (gnt_data_q) begin
              data_ack <= 1'b1;
              if (!we_q) data_rdata <= sample;
            end else begin
              inst_ack   <= 1'b1;
              inst_rdata <= sample;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
            // Release we_n for the final hold cycle while the bus stays driven.
            if (we_q && (cnt_q + 4'd1 == WaitLast)) begin
              if (sel_base_q) base_ram_we_n <= 1'b1;
              if (sel_ext_q)  ext_ram_we_n  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
